pdm_multiclip_recorder: RTL and testbench

Parametrised successor of the two-clip PDM audio record/playback path. It generates the PDM microphone clock and deserialises microphone bits into words stored in one of `NUM_CLIPS` clip slots, each of configurable depth. It replays any recorded slot as a PDM bitstream on the audio output and tracks the recorded length of every slot. It sits between the board microphone/audio jack pins and the user buttons and switches in the top level.

---
 rtl/pdm_multiclip_recorder.sv | 201 ++++++++++++++++++++
 tb/tb_pdm_multiclip_recorder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_multiclip_recorder.sv
// pdm_multiclip_recorder: PDM mic capture into NUM_CLIPS slots with PDM playback.
// Define PDM_MONITOR_EN to echo sampled mic bits on the audio output during RECORD.
module pdm_multiclip_recorder #(
  parameter int CLK_DIV    = 25,
  parameter int WORD_W     = 16,
  parameter int NUM_CLIPS  = 4,
  parameter int CLIP_WORDS = 1024
) (
  input  logic                         clock_i,
  input  logic                         Reset,
  output logic                         pdm_clk_o,
  output logic                         pdm_lrsel_o,
  input  logic                         pdm_data_i,
  output logic                         pdm_audio_o,
  output logic                         pdm_sdaudio_o,
  input  logic                         record_i,
  input  logic                         play_i,
  input  logic                         stop_i,
  input  logic [$clog2(NUM_CLIPS)-1:0] clip_sel_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_CLIPS-1:0]         clip_valid_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(NUM_CLIPS);
  localparam int IW = $clog2(CLIP_WORDS);
  localparam int LW = $clog2(CLIP_WORDS + 1);
  localparam int CW = $clog2(WORD_W);
  localparam int AW = SW + IW;
  localparam logic [LW-1:0] FULL = LW'(CLIP_WORDS);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              pclk_q, pclk_d;
  logic              rec_prev_q, play_prev_q;
  logic [SW-1:0]     slot_q, slot_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              wr_pend_q, wr_pend_d;
  logic [LW-1:0]     len_q [NUM_CLIPS];
  logic [LW-1:0]     len_d [NUM_CLIPS];
  logic [LW-1:0]     ridx_q, ridx_d;
  logic [CW-1:0]     pbit_q, pbit_d;
  logic [WORD_W-1:0] osh_q, osh_d;
  logic              rdy_q, rdy_d;
  logic              audio_q, audio_d;
  logic              done_q, done_d;
  logic              we, rise, rec_edge, play_edge;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_q;
  logic [WORD_W-1:0] mem [NUM_CLIPS*CLIP_WORDS];

  assign rise        = (div_q == DW'(CLK_DIV - 1)) && !pclk_q;
  assign div_d       = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
  assign pclk_d      = (div_q == DW'(CLK_DIV - 1)) ? ~pclk_q : pclk_q;
  assign rec_edge    = record_i && !rec_prev_q;
  assign play_edge   = play_i && !play_prev_q;
  assign rd_addr     = {slot_q, ridx_q[IW-1:0]};
  assign pdm_clk_o   = pclk_q;
  assign pdm_lrsel_o = 1'b0;
  assign pdm_audio_o = audio_q;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
`ifdef PDM_MONITOR_EN
  assign pdm_sdaudio_o = state_q != IDLE;
`else
  assign pdm_sdaudio_o = state_q == PLAY;
`endif

  always_comb begin
    clip_valid_o = '0;
    for (int k = 0; k < NUM_CLIPS; k++) clip_valid_o[k] = len_q[k] != '0;
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    wr_pend_d = 1'b0;
    len_d     = len_q;
    ridx_d    = ridx_q;
    pbit_d    = pbit_q;
    osh_d     = osh_q;
    rdy_d     = 1'b0;
    audio_d   = audio_q;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        audio_d = 1'b0;
        if (rec_edge) begin
          state_d             = RECORD;
          slot_d              = clip_sel_i;
          len_d[clip_sel_i]   = '0;
          idx_d               = '0;
          bcnt_d              = '0;
        end else if (play_edge && len_q[clip_sel_i] != '0) begin
          state_d = PLAY;
          slot_d  = clip_sel_i;
          ridx_d  = '0;
          pbit_d  = '0;
        end
      end
      RECORD: begin
        if (wr_pend_q) begin
          we            = 1'b1;
          len_d[slot_q] = len_q[slot_q] + LW'(1);
          idx_d         = idx_q + IW'(1);
        end
        if (rise) begin
          sh_d      = {sh_q[WORD_W-2:0], pdm_data_i};
          wr_pend_d = bcnt_q == CW'(WORD_W - 1);
          bcnt_d    = (bcnt_q == CW'(WORD_W - 1)) ? '0 : bcnt_q + CW'(1);
`ifdef PDM_MONITOR_EN
          audio_d   = pdm_data_i;
`endif
        end
        // a word still being shifted in when stop arrives is dropped
        if (stop_i || len_q[slot_q] == FULL) begin
          state_d   = IDLE;
          wr_pend_d = 1'b0;
          audio_d   = 1'b0;
        end
      end
      PLAY: begin
        rdy_d = 1'b1;
        // rdy_q guards the first tick until the prefetched word has landed in rd_q
        if (rise && rdy_q) begin
          if (pbit_q != '0) begin
            audio_d = osh_q[WORD_W-1];
            osh_d   = osh_q << 1;
            pbit_d  = pbit_q - CW'(1);
          end else if (ridx_q == len_q[slot_q]) begin
            state_d = IDLE;
            audio_d = 1'b0;
          end else begin
            audio_d = rd_q[WORD_W-1];
            osh_d   = rd_q << 1;
            pbit_d  = CW'(WORD_W - 1);
            ridx_d  = ridx_q + LW'(1);
          end
        end
        if (stop_i) begin
          state_d = IDLE;
          audio_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clock_i or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      pclk_q      <= 1'b0;
      rec_prev_q  <= 1'b0;
      play_prev_q <= 1'b0;
      slot_q      <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      wr_pend_q   <= 1'b0;
      for (int k = 0; k < NUM_CLIPS; k++) len_q[k] <= '0;
      ridx_q      <= '0;
      pbit_q      <= '0;
      osh_q       <= '0;
      rdy_q       <= 1'b0;
      audio_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pclk_q      <= pclk_d;
      rec_prev_q  <= record_i;
      play_prev_q <= play_i;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      wr_pend_q   <= wr_pend_d;
      len_q       <= len_d;
      ridx_q      <= ridx_d;
      pbit_q      <= pbit_d;
      osh_q       <= osh_d;
      rdy_q       <= rdy_d;
      audio_q     <= audio_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (we) mem[{slot_q, idx_q}] <= sh_q;
    rd_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_pdm_multiclip_recorder.sv
// tb_pdm_multiclip_recorder: scoreboard bench; recorded bits are queued and compared on playback.
module tb_pdm_multiclip_recorder;
  localparam int CD = 2, WW = 4, NC = 2, CWD = 4;

  logic clk = 0, rst = 0, pdm_data = 0, rec = 0, play = 0, stop = 0;
  logic [0:0] sel = '0;
  logic pdm_clk, lrsel, audio, sdaudio, busy, done;
  logic [NC-1:0] valid;
  int vectors = 0, errors = 0;
  bit prev_clk = 0;
  bit exp_q[$];
  bit wb[$];

  pdm_multiclip_recorder #(.CLK_DIV(CD), .WORD_W(WW), .NUM_CLIPS(NC), .CLIP_WORDS(CWD)) dut (
    .clock_i(clk), .Reset(rst), .pdm_clk_o(pdm_clk), .pdm_lrsel_o(lrsel),
    .pdm_data_i(pdm_data), .pdm_audio_o(audio), .pdm_sdaudio_o(sdaudio),
    .record_i(rec), .play_i(play), .stop_i(stop), .clip_sel_i(sel),
    .busy_o(busy), .done_o(done), .clip_valid_o(valid));

  always #5 clk = ~clk;

  task automatic step(output bit r);
    @(negedge clk);
    r = pdm_clk && !prev_clk;
    prev_clk = pdm_clk;
  endtask

  task automatic do_record(input logic s, input int n, input logic [31:0] pat, output int got);
    bit r;
    int e = 0;
    got = 0;
    sel = s;
    pdm_data = pat[0];
    wb.delete();
    rec = 1;
    for (int c = 0; c < 400 && got < n; c++) begin
      step(r);
      e++;
      if (e == 1) begin
        rec = 0;
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rec_start_busy got %b want 1", busy); end
      end
      if (r && e >= 2) begin
        wb.push_back(pdm_data);
        got++;
        if (wb.size() == WW) begin
          foreach (wb[i]) exp_q.push_back(wb[i]);
          wb.delete();
        end
        pdm_data = pat[got];
      end
    end
    vectors++;
    if (got < n) begin errors++; $display("FAIL rec_timeout got %0d samples want %0d", got, n); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pdm_clk, lrsel, audio, sdaudio, busy, done, valid} !== 8'b0)
      begin errors++; $display("FAIL reset_outputs got %b want 00000000", {pdm_clk, lrsel, audio, sdaudio, busy, done, valid}); end
    prev_clk = 0;
    rst = 0;
  endtask

  task automatic test_clock();
    bit r;
    logic [31:0] ex;
    for (int k = 1; k <= 40; k++) begin
      step(r);
      ex = (k >> 1) & 1;
      vectors++;
      if (pdm_clk !== ex[0] || lrsel !== 1'b0)
        begin errors++; $display("FAIL clock_k%0d got clk=%b lrsel=%b want clk=%b lrsel=0", k, pdm_clk, lrsel, ex[0]); end
    end
  endtask

  task automatic test_record_full();
    bit r;
    int got, n = 0, dones = 0;
    do_record(1'b1, 16, 32'h0000_5555, got);
    do begin step(r); n++; if (done) dones++; end while (busy && n < 10);
    vectors++;
    if (n !== 2) begin errors++; $display("FAIL rec_full_exit_cycles got %0d want 2", n); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL rec_full_exit got busy=%b done=%b want 0 1", busy, done); end
    step(r);
    if (done) dones++;
    vectors++;
    if (dones !== 1) begin errors++; $display("FAIL rec_full_done_count got %0d want 1", dones); end
    vectors++;
    if (valid !== 2'b10) begin errors++; $display("FAIL rec_full_valid got %b want 10", valid); end
  endtask

  task automatic test_play(input logic s, input int nbits);
    bit r, ex, last = 0, fin = 0;
    int e = 0, bits = 0;
    sel = s;
    play = 1;
    for (int c = 0; c < 400 && !fin; c++) begin
      step(r);
      e++;
      if (e == 1) play = 0;
      if (r && e >= 3 && bits == nbits) begin
        fin = 1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b1 || audio !== 1'b0 || sdaudio !== 1'b0)
          begin errors++; $display("FAIL play_exit got busy=%b done=%b audio=%b sd=%b want 0 1 0 0", busy, done, audio, sdaudio); end
      end else if (r && e >= 3) begin
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL play_queue_empty got bit %0d want queued data", bits); end
        else begin
          ex = exp_q.pop_front();
          if (audio !== ex || busy !== 1'b1 || sdaudio !== 1'b1)
            begin errors++; $display("FAIL play_bit%0d got audio=%b busy=%b sd=%b want %b 1 1", bits, audio, busy, sdaudio, ex); end
          last = ex;
        end
        bits++;
      end else begin
        vectors++;
        if (audio !== last || busy !== 1'b1 || sdaudio !== 1'b1 || done !== 1'b0)
          begin errors++; $display("FAIL play_hold e%0d got audio=%b busy=%b sd=%b done=%b want %b 1 1 0", e, audio, busy, sdaudio, done, last); end
      end
    end
    vectors++;
    if (!fin) begin errors++; $display("FAIL play_timeout got %0d bits want %0d", bits, nbits); end
    step(r);
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL play_done_pulse got %b want 0", done); end
  endtask

  task automatic test_empty_slot();
    bit r;
    sel = 0;
    play = 1;
    for (int c = 0; c < 8; c++) begin
      step(r);
      play = 0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL empty_slot got busy=%b done=%b want 0 0", busy, done); end
    end
  endtask

  task automatic test_stop_priority();
    bit r;
    int got;
    do_record(1'b0, 6, 32'h0000_0013, got);
    stop = 1;
    step(r);
    stop = 0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1 || valid !== 2'b11)
      begin errors++; $display("FAIL stop_exit got busy=%b done=%b valid=%b want 0 1 11", busy, done, valid); end
    step(r);
    test_play(1'b0, 4);
    sel = 1;
    rec = 1;
    play = 1;
    step(r);
    rec = 0;
    play = 0;
    vectors++;
    if (busy !== 1'b1 || sdaudio !== 1'b0 || valid !== 2'b01)
      begin errors++; $display("FAIL priority got busy=%b sd=%b valid=%b want 1 0 01", busy, sdaudio, valid); end
    stop = 1;
    step(r);
    stop = 0;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL priority_stop got busy=%b want 0", busy); end
    step(r);
  endtask

  task automatic test_reset_mid_play();
    bit r;
    int c = 0;
    sel = 0;
    play = 1;
    do begin step(r); play = 0; c++; end while (audio !== 1'b1 && c < 40);
    vectors++;
    if (audio !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midplay_start got audio=%b busy=%b want 1 1", audio, busy); end
    step(r);
    #2 rst = 1;
    #1;
    vectors++;
    if ({busy, audio, sdaudio, done, pdm_clk, valid} !== 7'b0)
      begin errors++; $display("FAIL midplay_reset got %b want 0000000", {busy, audio, sdaudio, done, pdm_clk, valid}); end
    @(negedge clk);
    rst = 0;
    prev_clk = 0;
  endtask

  initial begin
    test_reset();
    test_clock();
    test_record_full();
    test_play(1'b1, 16);
    test_empty_slot();
    test_stop_priority();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
